// File: rtl/chip_host_driver.sv
// Host-side driver for the 12-pin chip: streams a stored program onto io_in,
// then watches io_out for the end-of-run register dump and captures it.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | program memory writable, waiting for start
// S_SEND      | streaming program words, each followed by GAP fill slots
// S_WAIT_DUMP | watching io_out for a dump start, timeout counter running
// S_CAPTURE   | collecting reg1..reg7 of the dump in order
// S_DONE      | captures frozen for readback, waiting for a re-run start
module chip_host_driver #(
    parameter int          PROG_DEPTH = 16,
    parameter int          GAP        = 0,
    parameter logic [11:0] FILL       = 12'hE00,
    parameter int          TIMEOUT    = 255
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0]   prog_addr,
    input  logic [11:0]                     prog_data,
    input  logic [$clog2(PROG_DEPTH):0]     prog_len,
    input  logic                            start,
    output logic [11:0]                     chip_io_in,
    input  logic [11:0]                     chip_io_out,
    output logic                            busy,
    output logic                            done,
    output logic                            timeout,
    output logic                            proto_err,
    output logic [5:0]                      final_cycles,
    input  logic [2:0]                      dump_rd_addr,
    output logic [2:0]                      dump_rd_data
);

    localparam int AW = $clog2(PROG_DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);
    localparam logic [GW-1:0] GAP_LD = GW'(GAP);
    localparam logic [7:0]    TMR_LD = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_DUMP,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [11:0]   mem [PROG_DEPTH];
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx_q;
    logic [GW-1:0] slot_q;
    logic [7:0]    tmr_q;
    logic [5:0]    prev_cyc_q;
    logic          prev_vld_q;
    logic [2:0]    expect_q;
    logic [5:0]    cyc_q;
    logic [2:0]    reg_q [8];
    logic          timeout_q;
    logic          proto_err_q;

    logic [5:0] io_cyc;
    logic [2:0] io_addr;
    logic [2:0] io_data;
    logic       start_ok;
    logic       slot_tc;
    logic       last_word;
    logic       dump_start;
    logic       cap_ok;
    logic       tmr_tc;

    assign io_cyc  = chip_io_out[11:6];
    assign io_addr = chip_io_out[5:3];
    assign io_data = chip_io_out[2:0];

    assign start_ok   = start && (state == S_IDLE || state == S_DONE);
    assign slot_tc    = (slot_q == '0);
    assign last_word  = ((idx_q + LW'(1)) == len_q);
    // A wrapping cycle field (63 -> 0) never compares equal, so it cannot fake a dump start.
    assign dump_start = prev_vld_q && (prev_cyc_q == io_cyc) && (io_addr == 3'd0);
    assign cap_ok     = (io_addr == expect_q) && (io_cyc == cyc_q);
    assign tmr_tc     = (tmr_q == 8'd0);

    always_ff @(posedge clk) begin
        if (prog_we && state == S_IDLE) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        chip_io_in = FILL;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_next = (prog_len == '0) ? S_WAIT_DUMP : S_SEND;
                end
            end
            S_SEND: begin
                if (slot_q == GAP_LD) begin
                    chip_io_in = mem[idx_q[AW-1:0]];
                end
                if (slot_tc && last_word) begin
                    state_next = S_WAIT_DUMP;
                end
            end
            S_WAIT_DUMP: begin
                if (dump_start) begin
                    state_next = S_CAPTURE;
                end else if (tmr_tc) begin
                    state_next = S_DONE;
                end
            end
            S_CAPTURE: begin
                if (!cap_ok) begin
                    state_next = S_WAIT_DUMP;
                end else if (expect_q == 3'd7) begin
                    state_next = S_DONE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= '0;
            idx_q       <= '0;
            slot_q      <= '0;
            tmr_q       <= '0;
            prev_cyc_q  <= '0;
            prev_vld_q  <= 1'b0;
            expect_q    <= '0;
            cyc_q       <= '0;
            timeout_q   <= 1'b0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                reg_q[i] <= '0;
            end
        end else begin
            prev_cyc_q <= io_cyc;
            // The first sample after entering WAIT_DUMP has no valid predecessor.
            prev_vld_q <= (state == S_WAIT_DUMP);

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        len_q       <= prog_len;
                        idx_q       <= '0;
                        slot_q      <= GAP_LD;
                        timeout_q   <= 1'b0;
                        proto_err_q <= 1'b0;
                        cyc_q       <= '0;
                        for (int i = 0; i < 8; i++) begin
                            reg_q[i] <= '0;
                        end
                    end
                end
                S_SEND: begin
                    if (slot_tc) begin
                        slot_q <= GAP_LD;
                        idx_q  <= idx_q + LW'(1);
                    end else begin
                        slot_q <= slot_q - GW'(1);
                    end
                end
                S_WAIT_DUMP: begin
                    if (dump_start) begin
                        reg_q[0] <= io_data;
                        cyc_q    <= io_cyc;
                        expect_q <= 3'd1;
                    end else if (tmr_tc) begin
                        timeout_q <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (cap_ok) begin
                        reg_q[expect_q] <= io_data;
                        expect_q        <= expect_q + 3'd1;
                    end else begin
                        proto_err_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase

            if (state_next == S_WAIT_DUMP && state != S_WAIT_DUMP) begin
                tmr_q <= TMR_LD;
            end else if (state == S_WAIT_DUMP && !tmr_tc) begin
                tmr_q <= tmr_q - 8'd1;
            end
        end
    end

    assign busy         = (state == S_SEND) || (state == S_WAIT_DUMP) || (state == S_CAPTURE);
    assign done         = (state == S_DONE);
    assign timeout      = timeout_q;
    assign proto_err    = proto_err_q;
    assign final_cycles = cyc_q;
    assign dump_rd_data = reg_q[dump_rd_addr];

endmodule

// File: tb/tb_chip_host_driver.sv
// Self-checking bench for chip_host_driver: scenario tasks drive randomized
// programs and io_out sequences and compare against values built from the rules.
module tb_chip_host_driver;

    localparam int          TMO      = 20;
    localparam logic [11:0] FILL     = 12'hE00;
    localparam logic [11:0] IDLE_OUT = 12'h038;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [11:0] prog_data = '0;
    logic [4:0]  prog_len = '0;
    logic        start = 1'b0;
    logic [11:0] chip_io_in;
    logic [11:0] chip_io_out = IDLE_OUT;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        proto_err;
    logic [5:0]  final_cycles;
    logic [2:0]  dump_rd_addr = '0;
    logic [2:0]  dump_rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] prog_words [4];
    logic [2:0]  exp_regs [8];

    chip_host_driver #(
        .PROG_DEPTH(16),
        .GAP(0),
        .FILL(FILL),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .prog_we(prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .prog_len(prog_len),
        .start(start),
        .chip_io_in(chip_io_in),
        .chip_io_out(chip_io_out),
        .busy(busy),
        .done(done),
        .timeout(timeout),
        .proto_err(proto_err),
        .final_cycles(final_cycles),
        .dump_rd_addr(dump_rd_addr),
        .dump_rd_data(dump_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] mk(input logic [5:0] cyc, input logic [2:0] addr, input logic [2:0] data);
        return {cyc, addr, data};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [4:0] len);
        prog_len = len;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic write_prog(input logic [3:0] addr, input logic [11:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        step();
        prog_we   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, n);
        end
    endtask

    task automatic test_reset();
        n_tests++; if (chip_io_in !== FILL) begin n_fail++; $display("FAIL reset_io_in: got %h, required %h", chip_io_in, FILL); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b, required 0", timeout); end
        n_tests++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %b, required 0", proto_err); end
        n_tests++; if (final_cycles !== 6'd0) begin n_fail++; $display("FAIL reset_final: got %0d, required 0", final_cycles); end
        for (int i = 0; i < 8; i++) begin
            dump_rd_addr = 3'(i);
            #1;
            n_tests++;
            if (dump_rd_data !== 3'd0) begin n_fail++; $display("FAIL reset_reg%0d: got %0d, required 0", i, dump_rd_data); end
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_send();
        for (int k = 0; k < 4; k++) begin
            prog_words[k] = 12'($urandom);
            write_prog(4'(k), prog_words[k]);
        end
        do_start(5'd4);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (chip_io_in !== prog_words[k]) begin n_fail++; $display("FAIL send_word%0d: got %h, required %h", k, chip_io_in, prog_words[k]); end
            n_tests++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL send_busy%0d: got %b, required 1", k, busy); end
            step();
        end
        n_tests++; if (chip_io_in !== FILL) begin n_fail++; $display("FAIL send_fill_after: got %h, required %h", chip_io_in, FILL); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL send_wait_busy: got %b, required 1", busy); end
        wait_done(4 * TMO);
        n_tests++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL send_timeout: got %b, required 1", timeout); end
    endtask

    task automatic test_timeout();
        int n = 0;
        do_start(5'd0);
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_cleared: got %b, required 0", timeout); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tmo_busy: got %b, required 1", busy); end
        while (done !== 1'b1 && n < 4 * TMO) begin
            step();
            n++;
        end
        n_tests++; if (n != TMO) begin n_fail++; $display("FAIL tmo_latency: got %0d cycles, required %0d", n, TMO); end
        n_tests++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b, required 1", timeout); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy_end: got %b, required 0", busy); end
    endtask

    task automatic test_modelled_dump();
        logic [11:0] seq [$];
        for (int i = 0; i < 8; i++) exp_regs[i] = 3'($urandom);
        exp_regs[0] = 3'd3;
        exp_regs[1] = 3'd1;
        exp_regs[7] = 3'd6;
        seq.push_back(mk(6'd5, 3'd7, 3'd0));
        seq.push_back(mk(6'd6, 3'd7, 3'd0));
        seq.push_back(mk(6'd7, 3'd5, 3'd2));
        for (int i = 0; i < 8; i++) seq.push_back(mk(6'd7, 3'(i), exp_regs[i]));
        do_start(5'd0);
        for (int j = 0; j < seq.size(); j++) begin
            chip_io_out = seq[j];
            step();
            if (j == seq.size() - 2) begin
                n_tests++;
                if (done !== 1'b0) begin n_fail++; $display("FAIL dump_early_done: got %b, required 0", done); end
            end
        end
        chip_io_out = IDLE_OUT;
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL dump_done: got %b, required 1", done); end
        n_tests++; if (final_cycles !== 6'd7) begin n_fail++; $display("FAIL dump_final: got %0d, required 7", final_cycles); end
        n_tests++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL dump_proto_err: got %b, required 0", proto_err); end
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL dump_timeout: got %b, required 0", timeout); end
        for (int i = 0; i < 8; i++) begin
            dump_rd_addr = 3'(i);
            #1;
            n_tests++;
            if (dump_rd_data !== exp_regs[i]) begin n_fail++; $display("FAIL dump_reg%0d: got %0d, required %0d", i, dump_rd_data, exp_regs[i]); end
        end
        // A second dump after DONE must leave the captures untouched.
        chip_io_out = mk(6'd9, 3'd3, 3'd0);
        step();
        for (int i = 0; i < 8; i++) begin
            chip_io_out = mk(6'd9, 3'(i), ~exp_regs[i]);
            step();
        end
        chip_io_out = IDLE_OUT;
        n_tests++; if (final_cycles !== 6'd7) begin n_fail++; $display("FAIL redump_final: got %0d, required 7", final_cycles); end
        for (int i = 0; i < 8; i++) begin
            dump_rd_addr = 3'(i);
            #1;
            n_tests++;
            if (dump_rd_data !== exp_regs[i]) begin n_fail++; $display("FAIL redump_reg%0d: got %0d, required %0d", i, dump_rd_data, exp_regs[i]); end
        end
        step();
    endtask

    task automatic test_wrap();
        logic [5:0] cycs [4];
        cycs[0] = 6'd62; cycs[1] = 6'd63; cycs[2] = 6'd0; cycs[3] = 6'd1;
        do_start(5'd0);
        for (int j = 0; j < 4; j++) begin
            chip_io_out = mk(cycs[j], 3'd0, 3'(j + 1));
            step();
            n_tests++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL wrap_busy%0d: got %b, required 1", j, busy); end
        end
        chip_io_out = IDLE_OUT;
        n_tests++; if (final_cycles !== 6'd0) begin n_fail++; $display("FAIL wrap_final: got %0d, required 0", final_cycles); end
        wait_done(4 * TMO);
        n_tests++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL wrap_timeout: got %b, required 1", timeout); end
        dump_rd_addr = 3'd0;
        #1;
        n_tests++; if (dump_rd_data !== 3'd0) begin n_fail++; $display("FAIL wrap_reg0: got %0d, required 0", dump_rd_data); end
        step();
    endtask

    task automatic test_broken_dump();
        logic [5:0] c;
        logic [5:0] d;
        logic [2:0] a [8];
        c = 6'($urandom_range(0, 62));
        d = 6'($urandom);
        for (int i = 0; i < 8; i++) begin
            a[i]        = 3'($urandom);
            exp_regs[i] = 3'($urandom);
        end
        do_start(5'd0);
        chip_io_out = mk(c, 3'd6, 3'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            chip_io_out = mk(c, 3'(i), a[i]);
            step();
        end
        chip_io_out = mk(c + 6'd1, 3'd0, a[4]);
        step();
        n_tests++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL broken_proto_err: got %b, required 1", proto_err); end
        n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL broken_state: busy=%b done=%b, required busy=1 done=0", busy, done); end
        chip_io_out = mk(d, 3'd5, 3'd0);
        step();
        for (int i = 0; i < 8; i++) begin
            chip_io_out = mk(d, 3'(i), exp_regs[i]);
            step();
        end
        chip_io_out = IDLE_OUT;
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL reclean_done: got %b, required 1", done); end
        n_tests++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL reclean_proto_err: got %b, required 1", proto_err); end
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reclean_timeout: got %b, required 0", timeout); end
        n_tests++; if (final_cycles !== d) begin n_fail++; $display("FAIL reclean_final: got %0d, required %0d", final_cycles, d); end
        for (int i = 0; i < 8; i++) begin
            dump_rd_addr = 3'(i);
            #1;
            n_tests++;
            if (dump_rd_data !== exp_regs[i]) begin n_fail++; $display("FAIL reclean_reg%0d: got %0d, required %0d", i, dump_rd_data, exp_regs[i]); end
        end
        step();
    endtask

    task automatic test_reset_mid_send();
        do_start(5'd4);
        step();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b, required 1", busy); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (chip_io_in !== FILL) begin n_fail++; $display("FAIL midrst_io_in: got %h, required %h", chip_io_in, FILL); end
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: busy=%b done=%b, required 0 0", busy, done); end
        step();
        n_tests++; if (chip_io_in !== FILL || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_next: io_in=%h busy=%b done=%b, required %h 0 0", chip_io_in, busy, done, FILL); end
        #2;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_chip_connected();
        logic [2:0]  r [8];
        logic [5:0]  cyc;
        logic [5:0]  frozen;
        logic [11:0] w;
        int          words_seen = 0;
        for (int i = 0; i < 8; i++) r[i] = 3'($urandom);
        cyc = 6'($urandom_range(0, 40));
        write_prog(4'd0, 12'h040);
        do_start(5'd1);
        n_tests++; if (chip_io_in !== 12'h040) begin n_fail++; $display("FAIL chip_word0: got %h, required 040", chip_io_in); end
        for (int t = 0; t < 4; t++) begin
            w = chip_io_in;
            if (w !== FILL) begin
                words_seen++;
                if (w[11:9] == 3'd0) r[w[8:6]] = r[w[5:3]] + r[w[2:0]];
            end
            chip_io_out = mk(cyc, 3'd7, 3'd0);
            frozen      = cyc;
            cyc         = cyc + 6'd1;
            step();
        end
        n_tests++; if (words_seen != 1) begin n_fail++; $display("FAIL chip_word_count: got %0d, required 1", words_seen); end
        for (int i = 0; i < 8; i++) begin
            chip_io_out = mk(frozen, 3'(i), r[i]);
            step();
        end
        chip_io_out = IDLE_OUT;
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL chip_done: got %b, required 1", done); end
        n_tests++; if (final_cycles !== frozen) begin n_fail++; $display("FAIL chip_final: got %0d, required %0d", final_cycles, frozen); end
        for (int i = 0; i < 8; i++) begin
            exp_regs[i]  = r[i];
            dump_rd_addr = 3'(i);
            #1;
            n_tests++;
            if (dump_rd_data !== exp_regs[i]) begin n_fail++; $display("FAIL chip_reg%0d: got %0d, required %0d", i, dump_rd_data, exp_regs[i]); end
        end
        step();
    endtask

    task automatic test_back_to_back();
        write_prog(4'd0, 12'hABC);
        do_start(5'd1);
        n_tests++; if (chip_io_in !== 12'h040) begin n_fail++; $display("FAIL b2b_word0: got %h, required 040", chip_io_in); end
        n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_flags: busy=%b done=%b, required 1 0", busy, done); end
        n_tests++; if (final_cycles !== 6'd0 || proto_err !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL b2b_cleared: final=%0d perr=%b tmo=%b, required 0 0 0", final_cycles, proto_err, timeout); end
        dump_rd_addr = 3'd1;
        #1;
        n_tests++; if (dump_rd_data !== 3'd0) begin n_fail++; $display("FAIL b2b_reg1: got %0d, required 0", dump_rd_data); end
        step();
        n_tests++; if (chip_io_in !== FILL) begin n_fail++; $display("FAIL b2b_fill: got %h, required %h", chip_io_in, FILL); end
        wait_done(4 * TMO);
        n_tests++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL b2b_timeout: got %b, required 1", timeout); end
    endtask

    initial begin
        step();
        step();
        test_reset();
        test_send();
        test_timeout();
        test_modelled_dump();
        test_wrap();
        test_broken_dump();
        test_reset_mid_send();
        test_chip_connected();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
